// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the AHB-to-APB bridge state encoding.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY   = 1'b0;
  localparam logic HRESP_ERROR  = 1'b1;

  localparam logic HWRITE_READ  = 1'b0;
  localparam logic HWRITE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLATCH = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } bridge_state_e;

endpackage

// File: rtl/ahb2apb_timeout.sv
// Counts stalled APB access cycles; expired flags the TIMEOUT-th stalled cycle.
// Latency: expired is combinational on enable; the count is cleared synchronously.
module ahb2apb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge HCLK) begin
    if (HRESET || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The stalled cycle that brings the count to TIMEOUT is the one that aborts.
  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB slave to multi-peripheral APB bridge; reads finish 3 cycles and writes 4 cycles after capture.
// HREADY_O is held low for the whole APB transfer, stretched by PREADY until the timeout fires.
module ahb2apb_bridge
  import ahb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int P_NUM   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [AW-1:0]       HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [DW/8-1:0]     HWSTRB,
  input  logic [DW-1:0]       HWDATA,
  input  logic                HREADY_I,
  output logic                HREADY_O,
  output logic                HRESP,
  output logic [DW-1:0]       HRDATA,
  output logic [AW-1:0]       PADDR,
  output logic [P_NUM-1:0]    PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [DW-1:0]       PWDATA,
  output logic [DW/8-1:0]     PSTRB,
  input  logic [P_NUM*DW-1:0] PRDATA,
  input  logic [P_NUM-1:0]    PREADY,
  input  logic [P_NUM-1:0]    PSLVERR
);

  bridge_state_e    state, state_nxt;
  logic [3:0]       dec_idx;
  logic [P_NUM-1:0] sel_dec, sel_q;
  logic             idx_bad, capture, ack, slverr, expired, tmo_en;
  logic [DW-1:0]    rdata_mux;
  logic             unused_sigs;

  assign unused_sigs = ^{HSIZE, HTRANS[0]};

  // Peripheral index sits directly below the interconnect's own slave field.
  assign dec_idx = HADDR[AW-5 -: 4];
  assign idx_bad = int'(dec_idx) >= P_NUM;
  assign capture = HSEL && HTRANS[1] && HREADY_I &&
                   (state == ST_IDLE || state == ST_DONE || state == ST_ERR2);

  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < P_NUM; i++) begin
      sel_dec[i] = (dec_idx == 4'(i));
    end
  end

  assign ack    = |(PREADY & sel_q);
  assign slverr = |(PSLVERR & sel_q);

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < P_NUM; i++) begin
      if (sel_q[i]) rdata_mux = rdata_mux | PRDATA[i*DW +: DW];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    HREADY_O  = 1'b1;
    HRESP     = HRESP_OKAY;
    PSEL      = '0;
    PENABLE   = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (state == ST_ERR2) HRESP = HRESP_ERROR;
        if (!capture)                    state_nxt = ST_IDLE;
        else if (idx_bad)                state_nxt = ST_ERR1;
        else if (HWRITE == HWRITE_WRITE) state_nxt = ST_WLATCH;
        else                             state_nxt = ST_SETUP;
      end
      ST_WLATCH: begin
        HREADY_O  = 1'b0;
        state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        HREADY_O  = 1'b0;
        PSEL      = sel_q;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        HREADY_O = 1'b0;
        PSEL     = sel_q;
        PENABLE  = 1'b1;
        if (ack)          state_nxt = slverr ? ST_ERR1 : ST_DONE;
        else if (expired) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        HREADY_O  = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PSTRB  <= '0;
      PWDATA <= '0;
      HRDATA <= '0;
      sel_q  <= '0;
    end else begin
      if (capture) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
        PSTRB  <= (HWRITE == HWRITE_WRITE) ? HWSTRB : '0;
        sel_q  <= sel_dec;
      end
      if (state == ST_WLATCH) PWDATA <= HWDATA;
      if (state == ST_ACCESS && ack && !slverr && PWRITE == HWRITE_READ) HRDATA <= rdata_mux;
    end
  end

  assign tmo_en = (state == ST_ACCESS) && !ack;

  ahb2apb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .clear   (state_nxt == ST_SETUP),
    .enable  (tmo_en),
    .expired (expired)
  );

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench: transaction-level model expands each AHB transfer into per-cycle expected outputs.
`timescale 1ns/1ps
module tb_ahb2apb_bridge;
  import ahb_pkg::*;

  localparam int AW = 32, DW = 32, P_NUM = 4, TIMEOUT = 8, SW = DW / 8;

  logic HCLK = 1'b0;
  logic HRESET, HSEL, HWRITE, HREADY_I, HREADY_O, HRESP, PENABLE, PWRITE;
  logic [AW-1:0] HADDR, PADDR;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic [SW-1:0] HWSTRB, PSTRB;
  logic [DW-1:0] HWDATA, HRDATA, PWDATA;
  logic [P_NUM-1:0] PSEL, PREADY, PSLVERR;
  logic [P_NUM*DW-1:0] PRDATA;

  always #5 HCLK = ~HCLK;

  ahb2apb_bridge #(.AW(AW), .DW(DW), .P_NUM(P_NUM), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWSTRB(HWSTRB), .HWDATA(HWDATA),
    .HREADY_I(HREADY_I), .HREADY_O(HREADY_O), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    else n_pass++;
  endtask

  // Peripheral model: each peripheral returns a distinct word; ready after cur_waits stalled cycles.
  function automatic logic [DW-1:0] prd(int i);
    return 32'hC000_5A5A | (32'(i) << 24);
  endfunction

  for (genvar g = 0; g < P_NUM; g++) begin : g_prd
    assign PRDATA[g*DW +: DW] = prd(g);
  end

  int acc_cnt = 0, cur_waits = 0;
  logic [P_NUM-1:0] rdy_mask = '0, err_mask = '0;
  assign PREADY  = (acc_cnt >= cur_waits) ? rdy_mask : '0;
  assign PSLVERR = err_mask;

  always @(posedge HCLK) begin
    if (HRESET || !PENABLE || PREADY != '0) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
  end

  typedef struct {
    logic hready, hresp, penable, pwrite;
    logic [P_NUM-1:0] psel;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, hrdata;
    logic [SW-1:0] pstrb;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  logic [AW-1:0] m_paddr = '0;
  logic m_pwrite = 1'b0;
  logic [SW-1:0] m_pstrb = '0;
  logic [DW-1:0] m_pwdata = '0, m_hrdata = '0;

  function automatic exp_t snap(logic hr, logic rs, logic [P_NUM-1:0] ps, logic pe);
    exp_t e;
    e.hready = hr; e.hresp = rs; e.psel = ps; e.penable = pe;
    e.paddr = m_paddr; e.pwrite = m_pwrite; e.pstrb = m_pstrb;
    e.pwdata = m_pwdata; e.hrdata = m_hrdata;
    return e;
  endfunction

  // Expands one captured transfer into the cycles that follow the capture edge; returns their count.
  function automatic int build(logic [AW-1:0] addr, logic wr, logic [DW-1:0] wd,
                               logic [SW-1:0] st, int waits, logic err);
    int idx = int'(addr[AW-5 -: 4]);
    int n0 = exp_q.size();
    int n_acc;
    logic [P_NUM-1:0] onehot;
    m_paddr = addr; m_pwrite = wr; m_pstrb = wr ? st : '0;
    if (idx >= P_NUM) begin
      exp_q.push_back(snap(1'b0, 1'b1, '0, 1'b0));
      exp_q.push_back(snap(1'b1, 1'b1, '0, 1'b0));
      return exp_q.size() - n0;
    end
    onehot = P_NUM'(1) << idx;
    if (wr) begin
      exp_q.push_back(snap(1'b0, 1'b0, '0, 1'b0));
      m_pwdata = wd;
    end
    exp_q.push_back(snap(1'b0, 1'b0, onehot, 1'b0));
    n_acc = (waits >= TIMEOUT) ? TIMEOUT : waits + 1;
    for (int k = 0; k < n_acc; k++) exp_q.push_back(snap(1'b0, 1'b0, onehot, 1'b1));
    if (waits >= TIMEOUT || err) begin
      exp_q.push_back(snap(1'b0, 1'b1, '0, 1'b0));
      exp_q.push_back(snap(1'b1, 1'b1, '0, 1'b0));
    end else begin
      if (!wr) m_hrdata = prd(idx);
      exp_q.push_back(snap(1'b1, 1'b0, '0, 1'b0));
    end
    return exp_q.size() - n0;
  endfunction

  always @(posedge HCLK) begin
    #1;
    if (exp_q.size() > 0) cur_e = exp_q.pop_front();
    else cur_e = snap(1'b1, 1'b0, '0, 1'b0);
    check("HREADY_O", 64'(HREADY_O), 64'(cur_e.hready));
    check("HRESP",    64'(HRESP),    64'(cur_e.hresp));
    check("PSEL",     64'(PSEL),     64'(cur_e.psel));
    check("PENABLE",  64'(PENABLE),  64'(cur_e.penable));
    check("PADDR",    64'(PADDR),    64'(cur_e.paddr));
    check("PWRITE",   64'(PWRITE),   64'(cur_e.pwrite));
    check("PWDATA",   64'(PWDATA),   64'(cur_e.pwdata));
    check("PSTRB",    64'(PSTRB),    64'(cur_e.pstrb));
    check("HRDATA",   64'(HRDATA),   64'(cur_e.hrdata));
  end

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HREADY_I = 1'b1;
  endtask

  // Starts at a negedge, returns at the negedge of the final (ready) cycle with the bus idle.
  task automatic txn(logic [AW-1:0] addr, logic wr, logic [DW-1:0] wd, logic [SW-1:0] st,
                     int waits, logic err, output int len);
    int idx = int'(addr[AW-5 -: 4]);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = addr; HWRITE = wr; HWSTRB = st;
    HREADY_I = 1'b1; HWDATA = DW'($urandom());
    cur_waits = waits;
    rdy_mask = (idx < P_NUM) ? P_NUM'(1) << idx : '0;
    err_mask = err ? rdy_mask : '0;
    len = build(addr, wr, wd, st, waits, err);
    for (int k = 1; k < len; k++) begin
      @(negedge HCLK);
      // Stalled cycles carry a fresh NONSEQ that the bridge must ignore.
      HADDR = AW'($urandom()); HWRITE = 1'($urandom_range(0, 1)); HWSTRB = SW'($urandom());
      HWDATA = (k == 1 && wr) ? wd : DW'($urandom());
    end
    @(negedge HCLK);
    drive_idle();
  endtask

  task automatic idle_junk(int n);
    for (int k = 0; k < n; k++) begin
      HSEL = (k % 3 != 1); HTRANS = (k % 3 == 0) ? HTRANS_BUSY : HTRANS_NONSEQ;
      HREADY_I = (k % 3 != 2); HADDR = 32'h1100_0000;
      @(negedge HCLK);
    end
    drive_idle();
  endtask

  initial begin
    int len;
    HRESET = 1'b1; HSIZE = 3'b010; HADDR = '0; HWRITE = 1'b0; HWSTRB = '0; HWDATA = '0;
    drive_idle();
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    idle_junk(4);

    txn(32'h1100_0010, 1'b0, '0, 4'hF, 0, 1'b0, len);
    check("read_len", 64'(len), 64'd3);
    check("read_hrdata", 64'(HRDATA), 64'h0000_0000_C100_5A5A);
    idle_junk(2);

    txn(32'h1300_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, len);
    check("write_len", 64'(len), 64'd7);
    check("write_pwdata", 64'(PWDATA), 64'h0000_0000_DEAD_BEEF);
    idle_junk(1);

    txn(32'h1500_0000, 1'b0, '0, 4'h0, 0, 1'b0, len);
    check("badidx_len", 64'(len), 64'd2);
    check("badidx_hresp", 64'(HRESP), 64'd1);

    txn(32'h1200_0008, 1'b1, 32'h0123_4567, 4'hC, 0, 1'b1, len);
    check("slverr_len", 64'(len), 64'd5);
    txn(32'h1000_0000, 1'b0, '0, 4'h0, 1, 1'b0, len);
    check("b2b_hrdata", 64'(HRDATA), 64'h0000_0000_C000_5A5A);
    idle_junk(2);

    txn(32'h1200_0000, 1'b0, '0, 4'h0, 100, 1'b0, len);
    check("timeout_len", 64'(len), 64'd11);
    txn(32'h1300_0020, 1'b0, '0, 4'h0, TIMEOUT - 1, 1'b0, len);
    check("edge_len", 64'(len), 64'd10);
    check("edge_hrdata", 64'(HRDATA), 64'h0000_0000_C300_5A5A);

    txn(32'h1000_0100, 1'b1, 32'hA5A5_1234, 4'h3, 1, 1'b0, len);
    txn(32'h1100_0004, 1'b0, '0, 4'hF, 2, 1'b0, len);
    txn(32'h1F00_0000, 1'b1, 32'h7777_7777, 4'hF, 0, 1'b0, len);
    check("badw_pwdata", 64'(PWDATA), 64'h0000_0000_A5A5_1234);
    idle_junk(3);

    // Reset lands while the access is stalled; every output must read as reset next cycle.
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h1000_0040; HWRITE = 1'b0;
    cur_waits = 20; rdy_mask = 4'b0001; err_mask = '0;
    void'(build(32'h1000_0040, 1'b0, '0, 4'h0, 20, 1'b0));
    @(negedge HCLK); drive_idle();
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b1;
    exp_q.delete();
    m_paddr = '0; m_pwrite = 1'b0; m_pstrb = '0; m_pwdata = '0; m_hrdata = '0;
    @(negedge HCLK);
    check("rst_paddr", 64'(PADDR), 64'd0);
    check("rst_hresp", 64'(HRESP), 64'd0);
    HRESET = 1'b0;
    idle_junk(2);

    txn(32'h1100_0000, 1'b0, '0, 4'h0, 0, 1'b0, len);
    idle_junk(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
